// File: rtl/addsub_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// addsub_sequencer_pkg
// Shared definitions for the add/sub entry sequencer: default operand width and
// the FSM state encoding. The encoding is also what the LEDR state display
// decodes, so the numeric values are fixed.
// -----------------------------------------------------------------------------
package addsub_sequencer_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_EXEC = 2'b10,
        S_SHOW = 2'b11
    } state_e;

endpackage

// File: rtl/addsub_sequencer_if.sv
// -----------------------------------------------------------------------------
// addsub_sequencer_if
// Bundles board I/O (ENTER key, switches), the adder connection and the display
// outputs of the sequencer.
//   slave  : the sequencer side (drives alu_*, result*, disp_en, state_out)
//   master : the board/adder side (drives enter_n, op_sub, sw_val, alu_sum, alu_ovf)
// -----------------------------------------------------------------------------
interface addsub_sequencer_if
    import addsub_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) ();

    logic             enter_n;
    logic             op_sub;
    logic [WIDTH-1:0] sw_val;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_sub;
    logic [WIDTH-1:0] alu_sum;
    logic             alu_ovf;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             ovf_flag;
    logic             disp_en;
    logic [1:0]       state_out;

    modport slave (
        input  enter_n, op_sub, sw_val, alu_sum, alu_ovf,
        output alu_a, alu_b, alu_sub, result, result_valid, ovf_flag,
               disp_en, state_out
    );

    modport master (
        output enter_n, op_sub, sw_val, alu_sum, alu_ovf,
        input  alu_a, alu_b, alu_sub, result, result_valid, ovf_flag,
               disp_en, state_out
    );

endinterface

// File: rtl/addsub_sequencer_key_debounce.sv
// -----------------------------------------------------------------------------
// addsub_sequencer_key_debounce
// Synchronises a raw active-low pushbutton, debounces it and emits a single
// one-cycle press pulse on each debounced falling edge.
//   clk    in  system clock
//   rst_n  in  async active-low reset (sync flops and level reset to released)
//   key_n  in  raw, asynchronous, bouncy active-low key
//   press  out one-cycle pulse per debounced press (registered)
// -----------------------------------------------------------------------------
module addsub_sequencer_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic [CW-1:0] count_r;
    logic          press_r;

    // Synchroniser, stable-count debounce and press pulse generation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            level_r <= 1'b1;
            count_r <= CNT_ZERO;
            press_r <= 1'b0;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
            if (sync2_r != level_r) begin
                // The level flips on the N-th consecutive differing cycle.
                if (count_r == CNT_LAST) begin
                    level_r <= sync2_r;
                    count_r <= CNT_ZERO;
                    press_r <= ~sync2_r;
                end else begin
                    count_r <= count_r + CNT_ONE;
                    press_r <= 1'b0;
                end
            end else begin
                // Any agreement with the current level restarts the count.
                count_r <= CNT_ZERO;
                press_r <= 1'b0;
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/addsub_sequencer.sv
// -----------------------------------------------------------------------------
// addsub_sequencer
// Steps the user through operand A, operand B (+ operation), a one-cycle
// execute that captures the external adder's result and overflow, and a show
// state that holds them for the display. No arithmetic is done here.
//   MAX10_CLK1_50 in  system clock, rising edge
//   RESET_N       in  async active-low reset
//   bus           slave modport: ENTER key, switches, adder link, display outputs
// -----------------------------------------------------------------------------
module addsub_sequencer
    import addsub_sequencer_pkg::*;
#(
    parameter int WIDTH           = WIDTH_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_CYCLES    = 25000000
) (
    input  logic                 MAX10_CLK1_50,
    input  logic                 RESET_N,
    addsub_sequencer_if.slave    bus
);

    localparam int            BW         = $clog2(BLINK_CYCLES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_ZERO = {BW{1'b0}};
    localparam logic [BW-1:0] BLINK_ONE  = BW'(1);

    state_e            state_r;
    state_e            state_next_s;
    logic              press_s;
    logic [WIDTH-1:0]  alu_a_r;
    logic [WIDTH-1:0]  alu_b_r;
    logic              alu_sub_r;
    logic [WIDTH-1:0]  result_r;
    logic              result_valid_r;
    logic              ovf_flag_r;
    logic              disp_en_r;
    logic [BW-1:0]     blink_cnt_r;

    addsub_sequencer_key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk   (MAX10_CLK1_50),
        .rst_n (RESET_N),
        .key_n (bus.enter_n),
        .press (press_s)
    );

    // FSM state register.
    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= S_A;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; S_EXEC always lasts exactly one cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_A: begin
                if (press_s) state_next_s = S_B;
                else         state_next_s = S_A;
            end
            S_B: begin
                if (press_s) state_next_s = S_EXEC;
                else         state_next_s = S_B;
            end
            S_EXEC: begin
                state_next_s = S_SHOW;
            end
            S_SHOW: begin
                if (press_s) state_next_s = S_A;
                else         state_next_s = S_SHOW;
            end
            default: begin
                state_next_s = S_A;
            end
        endcase
    end

    // Operand capture on presses and result capture in the execute cycle.
    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            alu_a_r        <= {WIDTH{1'b0}};
            alu_b_r        <= {WIDTH{1'b0}};
            alu_sub_r      <= 1'b0;
            result_r       <= {WIDTH{1'b0}};
            result_valid_r <= 1'b0;
            ovf_flag_r     <= 1'b0;
        end else begin
            case (state_r)
                S_A: begin
                    if (press_s) alu_a_r <= bus.sw_val;
                end
                S_B: begin
                    if (press_s) begin
                        alu_b_r   <= bus.sw_val;
                        alu_sub_r <= bus.op_sub;
                    end
                end
                S_EXEC: begin
                    result_r       <= bus.alu_sum;
                    ovf_flag_r     <= bus.alu_ovf;
                    result_valid_r <= 1'b1;
                end
                S_SHOW: begin
                    // Operands and result stay as-is; only the valid/overflow marks clear.
                    if (press_s) begin
                        result_valid_r <= 1'b0;
                        ovf_flag_r     <= 1'b0;
                    end
                end
                default: begin
                    result_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Overflow blink: disp_en starts at 1 and toggles every BLINK_CYCLES while
    // showing an overflowed result; anywhere else it is held steady at 1.
    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            blink_cnt_r <= BLINK_ZERO;
            disp_en_r   <= 1'b1;
        end else if ((state_r == S_SHOW) && ovf_flag_r && !press_s) begin
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_r <= BLINK_ZERO;
                disp_en_r   <= ~disp_en_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + BLINK_ONE;
            end
        end else begin
            blink_cnt_r <= BLINK_ZERO;
            disp_en_r   <= 1'b1;
        end
    end

    assign bus.alu_a        = alu_a_r;
    assign bus.alu_b        = alu_b_r;
    assign bus.alu_sub      = alu_sub_r;
    assign bus.result       = result_r;
    assign bus.result_valid = result_valid_r;
    assign bus.ovf_flag     = ovf_flag_r;
    assign bus.disp_en      = disp_en_r;
    assign bus.state_out    = state_r;

endmodule

// File: tb/tb_addsub_sequencer.sv
// -----------------------------------------------------------------------------
// tb_addsub_sequencer
// Self-checking bench: behavioural signed adder on the adder link, operands and
// expected results computed with integer arithmetic, randomized operand sets.
// -----------------------------------------------------------------------------
module tb_addsub_sequencer;

    localparam int W  = 4;
    localparam int DB = 4;
    localparam int BL = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    addsub_sequencer_if #(.WIDTH(W)) bus ();

    addsub_sequencer #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DB),
        .BLINK_CYCLES    (BL)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .RESET_N       (rst_n),
        .bus           (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural signed adder: exact integer result, overflow when out of range.
    always_comb begin
        int sa;
        int sb;
        int s;
        sa = int'($signed(bus.alu_a));
        sb = int'($signed(bus.alu_b));
        s  = bus.alu_sub ? (sa - sb) : (sa + sb);
        bus.alu_sum = s[W-1:0];
        bus.alu_ovf = (s > 7) || (s < -8);
    end

    // Hold ENTER low until the state display reaches target (bounded wait).
    task automatic press_to(input logic [1:0] target, input string name);
        bit found;
        found = 1'b0;
        bus.enter_n = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.state_out == target) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s: state_out=%b never reached required %b", name, bus.state_out, target);
        end
    endtask

    // Enter A then B; checks capture, S_EXEC latency and the captured result.
    task automatic enter_pair(input logic [3:0] a, input logic [3:0] b, input logic sub);
        int         s;
        logic [3:0] er;
        logic       eo;
        bit         found;
        s  = int'($signed(a)) + (sub ? -int'($signed(b)) : int'($signed(b)));
        er = s[3:0];
        eo = (s > 7) || (s < -8);

        bus.sw_val = a;
        bus.op_sub = ~sub;
        press_to(2'b01, "a_press");
        repeat (3) @(negedge clk);
        bus.sw_val  = 4'($urandom);
        bus.enter_n = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (bus.alu_a !== a) begin
            n_fail++;
            $display("FAIL alu_a: got %h required %h", bus.alu_a, a);
        end

        bus.sw_val  = b;
        bus.op_sub  = sub;
        bus.enter_n = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.state_out == 2'b10) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL exec_reach: state_out=%b required 10", bus.state_out);
        end else begin
            n_cmp++;
            if ({bus.result_valid, bus.alu_b, bus.alu_sub} !== {1'b0, b, sub}) begin
                n_fail++;
                $display("FAIL exec_cycle: valid/b/sub=%b/%h/%b required 0/%h/%b",
                         bus.result_valid, bus.alu_b, bus.alu_sub, b, sub);
            end
            @(negedge clk);
            bus.sw_val = 4'($urandom);
            bus.op_sub = 1'($urandom);
            n_cmp++;
            if ({bus.result_valid, bus.state_out, bus.result, bus.ovf_flag, bus.disp_en}
                !== {1'b1, 2'b11, er, eo, 1'b1}) begin
                n_fail++;
                $display("FAIL show: valid/state/result/ovf/disp=%b/%b/%h/%b/%b required 1/11/%h/%b/1 (a=%h b=%h sub=%b)",
                         bus.result_valid, bus.state_out, bus.result, bus.ovf_flag, bus.disp_en,
                         er, eo, a, b, sub);
            end
        end
        bus.enter_n = 1'b1;
    endtask

    // Leave S_SHOW with a press and check the cleared display flags.
    task automatic clear_show(input logic [3:0] keep_result);
        repeat (10) @(negedge clk);
        press_to(2'b00, "clear_press");
        n_cmp++;
        if ({bus.result_valid, bus.ovf_flag, bus.disp_en, bus.result}
            !== {1'b0, 1'b0, 1'b1, keep_result}) begin
            n_fail++;
            $display("FAIL clear: valid/ovf/disp/result=%b/%b/%b/%h required 0/0/1/%h",
                     bus.result_valid, bus.ovf_flag, bus.disp_en, bus.result, keep_result);
        end
        bus.enter_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.enter_n = 1'b1;
        bus.op_sub  = 1'b0;
        bus.sw_val  = 4'h0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        bus.sw_val = 4'h5;
        press_to(2'b01, "reset_pre_a");
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.state_out, bus.alu_a, bus.alu_b, bus.alu_sub, bus.result,
             bus.result_valid, bus.ovf_flag, bus.disp_en}
            !== {2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid: state=%b a=%h b=%h sub=%b res=%h v=%b ovf=%b disp=%b required all zero, disp=1",
                     bus.state_out, bus.alu_a, bus.alu_b, bus.alu_sub, bus.result,
                     bus.result_valid, bus.ovf_flag, bus.disp_en);
        end
        bus.enter_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (bus.state_out !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: state_out=%b required 00", bus.state_out);
        end
    endtask

    task automatic test_add_basic();
        int bad;
        enter_pair(4'b0110, 4'b0001, 1'b0);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.disp_en !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL steady_disp: disp_en low on %0d cycles required 0", bad);
        end
        clear_show(4'b0111);
    endtask

    task automatic test_overflow_blink();
        logic exp_d;
        enter_pair(4'b0110, 4'b0010, 1'b0);
        for (int k = 0; k < 40; k++) begin
            if (k != 0) @(negedge clk);
            exp_d = ((k / BL) % 2) == 0;
            n_cmp++;
            if (bus.disp_en !== exp_d) begin
                n_fail++;
                $display("FAIL blink k=%0d: disp_en=%b required %b", k, bus.disp_en, exp_d);
            end
        end
        clear_show(4'b1000);
    endtask

    task automatic test_mixed();
        logic [3:0] a;
        logic [3:0] b;
        logic       sub;
        int         s;
        enter_pair(4'b0110, 4'b1000, 1'b0);
        clear_show(4'b1110);
        enter_pair(4'b0110, 4'b0001, 1'b1);
        clear_show(4'b0101);
        enter_pair(4'b0110, 4'b1000, 1'b1);
        clear_show(4'b1110);
        for (int n = 0; n < 8; n++) begin
            a   = 4'($urandom);
            b   = 4'($urandom);
            sub = 1'($urandom);
            s   = int'($signed(a)) + (sub ? -int'($signed(b)) : int'($signed(b)));
            enter_pair(a, b, sub);
            clear_show(s[3:0]);
        end
    endtask

    task automatic test_glitch_hold();
        int waited;
        bus.enter_n = 1'b0;
        repeat (3) @(negedge clk);
        bus.enter_n = 1'b1;
        repeat (12) @(negedge clk);
        n_cmp++;
        if (bus.state_out !== 2'b00) begin
            n_fail++;
            $display("FAIL glitch: state_out=%b required 00", bus.state_out);
        end

        bus.sw_val  = 4'h3;
        bus.enter_n = 1'b0;
        waited = 0;
        while (bus.state_out != 2'b01 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        bus.sw_val = 4'hC;
        repeat (100 - waited) @(negedge clk);
        n_cmp++;
        if ({bus.state_out, bus.alu_a} !== {2'b01, 4'h3}) begin
            n_fail++;
            $display("FAIL hold: state/alu_a=%b/%h required 01/3", bus.state_out, bus.alu_a);
        end
        bus.enter_n = 1'b1;
        repeat (12) @(negedge clk);
        n_cmp++;
        if (bus.state_out !== 2'b01) begin
            n_fail++;
            $display("FAIL release: state_out=%b required 01", bus.state_out);
        end
        bus.sw_val = 4'h2;
        bus.op_sub = 1'b0;
        press_to(2'b11, "glitch_b");
        bus.enter_n = 1'b1;
        n_cmp++;
        if (bus.result !== 4'h5) begin
            n_fail++;
            $display("FAIL glitch_sum: result=%h required 5", bus.result);
        end
        clear_show(4'h5);
    endtask

    task automatic test_reset_exec();
        int bad;
        bus.sw_val = 4'h7;
        press_to(2'b01, "rx_a");
        bus.enter_n = 1'b1;
        repeat (10) @(negedge clk);
        bus.sw_val = 4'h7;
        bus.op_sub = 1'b0;
        press_to(2'b10, "rx_exec");
        rst_n = 1'b0;
        bus.enter_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if ({bus.state_out, bus.result_valid, bus.result, bus.alu_a, bus.ovf_flag}
            !== {2'b00, 1'b0, 4'h0, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_exec: state/valid/res/a/ovf=%b/%b/%h/%h/%b required 00/0/0/0/0",
                     bus.state_out, bus.result_valid, bus.result, bus.alu_a, bus.ovf_flag);
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.result_valid !== 1'b0 || bus.state_out !== 2'b00) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_exec_stay: %0d bad cycles required 0", bad);
        end
        enter_pair(4'b0011, 4'b0010, 1'b1);
        clear_show(4'b0001);
    endtask

    initial begin
        bus.enter_n = 1'b1;
        bus.op_sub  = 1'b0;
        bus.sw_val  = 4'h0;
        test_reset();
        test_add_basic();
        test_overflow_blink();
        test_mixed();
        test_glitch_hold();
        test_reset_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
